// File: rtl/fetch_decode_buffer.sv
// Pairs opcode words with their trailing 16-bit immediate before decode; 1-cycle registered outputs.
// stall freezes every register, flush clears them and wins over stall; no internal queueing.
module fetch_decode_buffer #(
    parameter logic [2:0]  IMM_OP   = 3'b110,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] in_instruction,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_next_pc,
    output logic [15:0] out_instruction,
    output logic [15:0] out_immediate,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic        out_valid,
    output logic        out_has_imm,
    output logic        imm_pending
);

    typedef enum logic {S_INSTR, S_IMM} state_t;

    state_t      state, stateNext;
    logic [15:0] pendingWord, pendingWordNext;
    logic [31:0] pendingPc, pendingPcNext;
    logic [15:0] instrNext, immNext;
    logic [31:0] pcNext, nextPcNext;
    logic        validNext, hasImmNext;

    always_comb begin
        stateNext       = state;
        pendingWordNext = pendingWord;
        pendingPcNext   = pendingPc;
        instrNext       = out_instruction;
        immNext         = out_immediate;
        pcNext          = out_pc;
        nextPcNext      = out_next_pc;
        validNext       = out_valid;
        hasImmNext      = out_has_imm;

        if (flush) begin
            stateNext       = S_INSTR;
            pendingWordNext = 16'h0000;
            pendingPcNext   = 32'h0;
            instrNext       = NOP_WORD;
            immNext         = 16'h0000;
            pcNext          = 32'h0;
            nextPcNext      = 32'h0;
            validNext       = 1'b0;
            hasImmNext      = 1'b0;
        end else if (!stall) begin
            case (state)
                S_INSTR: begin
                    if (in_instruction[15:13] == IMM_OP) begin
                        // Park the opcode; decode sees a bubble until its immediate arrives.
                        stateNext       = S_IMM;
                        pendingWordNext = in_instruction;
                        pendingPcNext   = in_pc;
                        instrNext       = NOP_WORD;
                        immNext         = 16'h0000;
                        validNext       = 1'b0;
                        hasImmNext      = 1'b0;
                    end else begin
                        instrNext  = in_instruction;
                        immNext    = 16'h0000;
                        pcNext     = in_pc;
                        nextPcNext = in_next_pc;
                        validNext  = 1'b1;
                        hasImmNext = 1'b0;
                    end
                end
                S_IMM: begin
                    // Word taken verbatim as data, whatever its top bits look like.
                    stateNext  = S_INSTR;
                    instrNext  = pendingWord;
                    immNext    = in_instruction;
                    pcNext     = pendingPc;
                    nextPcNext = in_next_pc;
                    validNext  = 1'b1;
                    hasImmNext = 1'b1;
                end
                default: stateNext = S_INSTR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_INSTR;
            pendingWord     <= 16'h0000;
            pendingPc       <= 32'h0;
            out_instruction <= NOP_WORD;
            out_immediate   <= 16'h0000;
            out_pc          <= 32'h0;
            out_next_pc     <= 32'h0;
            out_valid       <= 1'b0;
            out_has_imm     <= 1'b0;
        end else begin
            state           <= stateNext;
            pendingWord     <= pendingWordNext;
            pendingPc       <= pendingPcNext;
            out_instruction <= instrNext;
            out_immediate   <= immNext;
            out_pc          <= pcNext;
            out_next_pc     <= nextPcNext;
            out_valid       <= validNext;
            out_has_imm     <= hasImmNext;
        end
    end

    assign imm_pending = (state == S_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed scoreboard bench for fetch_decode_buffer: driver queues expected post-edge outputs,
// a monitor pops one entry per clock edge and compares.
module tb_fetch_decode_buffer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] in_instruction;
    logic [31:0] in_pc;
    logic [31:0] in_next_pc;
    logic [15:0] out_instruction;
    logic [15:0] out_immediate;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        out_valid;
    logic        out_has_imm;
    logic        imm_pending;

    fetch_decode_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .in_instruction  (in_instruction),
        .in_pc           (in_pc),
        .in_next_pc      (in_next_pc),
        .out_instruction (out_instruction),
        .out_immediate   (out_immediate),
        .out_pc          (out_pc),
        .out_next_pc     (out_next_pc),
        .out_valid       (out_valid),
        .out_has_imm     (out_has_imm),
        .imm_pending     (imm_pending)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic        full;     // 0: bubble, pc/next_pc/immediate not compared
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        valid;
        logic        hasImm;
        logic        immPend;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] stepId = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per active edge while the queue holds entries.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                bad = (out_instruction !== e.instr) || (out_valid !== e.valid) ||
                      (out_has_imm !== e.hasImm) || (imm_pending !== e.immPend);
                if (e.full)
                    bad = bad || (out_immediate !== e.imm) || (out_pc !== e.pc) ||
                          (out_next_pc !== e.npc);
                checks++;
                if (bad) begin
                    errors++;
                    $display("FAIL step%0d: got instr=%h imm=%h pc=%h npc=%h v=%b h=%b ip=%b, want instr=%h imm=%h pc=%h npc=%h v=%b h=%b ip=%b (full=%b)",
                             e.id, out_instruction, out_immediate, out_pc, out_next_pc,
                             out_valid, out_has_imm, imm_pending, e.instr, e.imm, e.pc,
                             e.npc, e.valid, e.hasImm, e.immPend, e.full);
                end
            end
        end
    end

    task automatic step(input logic [15:0] ins, input logic [31:0] pc, input logic [31:0] npc,
                        input logic st, input logic fl, input logic full,
                        input logic [15:0] eI, input logic [15:0] eM, input logic [31:0] eP,
                        input logic [31:0] eN, input logic eV, input logic eH, input logic eIP);
        exp_t e;
        @(negedge clk);
        in_instruction = ins;
        in_pc          = pc;
        in_next_pc     = npc;
        stall          = st;
        flush          = fl;
        stepId         = stepId + 8'd1;
        e = '{id: stepId, full: full, instr: eI, imm: eM, pc: eP, npc: eN,
              valid: eV, hasImm: eH, immPend: eIP};
        expQ.push_back(e);
    endtask

    task automatic checkReset(input string name);
        checks++;
        if (out_instruction !== 16'h0000 || out_immediate !== 16'h0000 || out_pc !== 32'h0 ||
            out_next_pc !== 32'h0 || out_valid !== 1'b0 || out_has_imm !== 1'b0 ||
            imm_pending !== 1'b0) begin
            errors++;
            $display("FAIL %s: got instr=%h imm=%h pc=%h npc=%h v=%b h=%b ip=%b, want all zero",
                     name, out_instruction, out_immediate, out_pc, out_next_pc,
                     out_valid, out_has_imm, imm_pending);
        end
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b1;
        flush          = 1'b1;
        in_instruction = 16'hC0DE;
        in_pc          = 32'h1234;
        in_next_pc     = 32'h1235;
        #3 checkReset("power_on_reset");
        @(posedge clk);
        #1 checkReset("reset_held_over_edge");
        @(negedge clk);
        flush = 1'b0;
        rst   = 1'b1;

        // One-word, then two-word, then opcode-shaped immediate.
        step(16'h2345, 32'd5,  32'd6,  0, 0, 1, 16'h2345, 16'h0000, 32'd5,  32'd6,  1, 0, 0);
        step(16'hC123, 32'd8,  32'd9,  0, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'hBEEF, 32'd9,  32'd10, 0, 0, 1, 16'hC123, 16'hBEEF, 32'd8,  32'd10, 1, 1, 0);
        step(16'hC001, 32'd20, 32'd21, 0, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'hC002, 32'd21, 32'd22, 0, 0, 1, 16'hC001, 16'hC002, 32'd20, 32'd22, 1, 1, 0);
        step(16'h1234, 32'd22, 32'd23, 0, 0, 1, 16'h1234, 16'h0000, 32'd22, 32'd23, 1, 0, 0);

        // Stall for three cycles in S_IMM with changing input words.
        step(16'hC123, 32'd8,  32'd9,  0, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'h1111, 32'd70, 32'd71, 1, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'hC222, 32'd72, 32'd73, 1, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'h3333, 32'd74, 32'd75, 1, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'hBEEF, 32'd9,  32'd10, 0, 0, 1, 16'hC123, 16'hBEEF, 32'd8,  32'd10, 1, 1, 0);

        // Stall while a valid instruction is held: nothing captured.
        step(16'h0042, 32'd30, 32'd31, 0, 0, 1, 16'h0042, 16'h0000, 32'd30, 32'd31, 1, 0, 0);
        step(16'hC555, 32'd31, 32'd32, 1, 0, 1, 16'h0042, 16'h0000, 32'd30, 32'd31, 1, 0, 0);

        // Flush with stall in S_IMM; the pending opcode must be gone afterwards.
        step(16'hC123, 32'd8,  32'd9,  0, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        step(16'hBEEF, 32'd9,  32'd10, 1, 1, 1, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 0);
        step(16'hBEEF, 32'd9,  32'd10, 0, 0, 1, 16'hBEEF, 16'h0000, 32'd9,  32'd10, 1, 0, 0);

        // Flush in S_INSTR suppresses an IMM opcode.
        step(16'hC777, 32'd40, 32'd41, 0, 1, 1, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 0);
        step(16'hE000, 32'd50, 32'd51, 0, 0, 1, 16'hE000, 16'h0000, 32'd50, 32'd51, 1, 0, 0);

        // PC wrap forwarded untouched.
        step(16'h0ABC, 32'hFFFFFFFF, 32'h0, 0, 0, 1, 16'h0ABC, 16'h0000, 32'hFFFFFFFF, 32'h0, 1, 0, 0);
        step(16'hDFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 0, 16'h0000, 16'h0000, 32'd0, 32'd0, 0, 0, 1);
        step(16'h0001, 32'hFFFFFFFF, 32'h0, 0, 0, 1, 16'hDFFF, 16'h0001, 32'hFFFFFFFE, 32'h0, 1, 1, 0);

        // Asynchronous reset mid-cycle while in S_IMM.
        step(16'hC123, 32'd8,  32'd9,  0, 0, 0, 16'h0000, 16'h0000, 32'd0,  32'd0,  0, 0, 1);
        @(negedge clk);
        stall          = 1'b1;
        in_instruction = 16'hBEEF;
        #2 rst = 1'b0;
        #1 checkReset("async_reset_mid_cycle");
        flush = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1 checkReset("reset_ignores_flush_stall");
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b1;
        rst   = 1'b1;
        step(16'h2345, 32'd5,  32'd6,  0, 0, 1, 16'h2345, 16'h0000, 32'd5,  32'd6,  1, 0, 0);
        step(16'h0007, 32'd6,  32'd7,  0, 0, 1, 16'h0007, 16'h0000, 32'd6,  32'd7,  1, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL have parameter IMM_OP, default 3'b110: value of instruction[15:13] that marks a two-word instruction (16-bit immediate follows).
REQ-002 SHALL have parameter NOP_WORD, default 16'h0000: instruction word driven during bubbles, flush and reset.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port stall, input, 1: hold all state and outputs this cycle.
REQ-006 SHALL have port flush, input, 1: discard buffered and pending content (jump taken or interrupt entry).
REQ-007 SHALL have port in_instruction, input, 16: word fetched at in_pc.
REQ-008 SHALL have port in_pc, input, 32: address of in_instruction (fetch samePc).
REQ-009 SHALL have port in_next_pc, input, 32: in_pc + 1 (fetch nextPc).
REQ-010 SHALL have port out_instruction, output, 16: instruction handed to decode.
REQ-011 SHALL have port out_immediate, output, 16: immediate word; 16'h0000 for one-word instructions.
REQ-012 SHALL have port out_pc, output, 32: address of the first word of out_instruction.
REQ-013 SHALL have port out_next_pc, output, 32: address following the last word of out_instruction.
REQ-014 SHALL have port out_valid, output, 1: outputs hold a complete instruction.
REQ-015 SHALL have port out_has_imm, output, 1: out_immediate is meaningful.
REQ-016 SHALL have port imm_pending, output, 1: high while in S_IMM.

Function
REQ-017 SHALL implement a two-state FSM: S_INSTR (expect opcode word) and S_IMM (expect immediate word).
REQ-018 SHALL give all outputs registered timing, updating only on clk rising edges or on reset assertion.
REQ-019 SHALL, in S_INSTR with stall=0 and flush=0 and in_instruction[15:13]!=IMM_OP, register out_instruction=in_instruction, out_immediate=0, out_pc=in_pc, out_next_pc=in_next_pc, out_valid=1, out_has_imm=0, and stay in S_INSTR (latency 1 cycle).
REQ-020 SHALL, in S_INSTR with stall=0 and flush=0 and in_instruction[15:13]==IMM_OP, save in_instruction and in_pc in internal pending registers, drive a bubble (out_instruction=NOP_WORD, out_valid=0, out_has_imm=0), and enter S_IMM.
REQ-021 SHALL, in S_IMM with stall=0 and flush=0, register out_instruction=pending word, out_immediate=in_instruction, out_pc=pending pc, out_next_pc=in_next_pc, out_valid=1, out_has_imm=1, and return to S_INSTR.
REQ-022 SHALL never decode the word received in S_IMM as an opcode, even when its bits [15:13] equal IMM_OP.
REQ-023 SHALL, when stall=1 and flush=0, hold the FSM state, pending registers and all outputs unchanged.
REQ-024 SHALL, when flush=1, regardless of stall or state, on the next edge set out_instruction=NOP_WORD, out_immediate=0, out_pc=0, out_next_pc=0, out_valid=0, out_has_imm=0, clear the pending registers, and enter S_INSTR.
REQ-025 SHALL give flush priority over stall, and stall priority over normal capture.
REQ-026 SHALL compute imm_pending combinationally from state only (1 in S_IMM, else 0).
REQ-027 SHALL pass 32-bit PCs unmodified, with no arithmetic; wrap-around of in_next_pc from 32'hFFFFFFFF to 0 is forwarded as given.

Reset
REQ-028 SHALL, while rst=0, immediately and asynchronously force state S_INSTR, pending registers 0, out_instruction=NOP_WORD, out_immediate=0, out_pc=0, out_next_pc=0, out_valid=0, out_has_imm=0, imm_pending=0.
REQ-029 SHALL, when reset asserts in S_IMM, discard the pending word; the first edge after rst returns high treats in_instruction as an opcode.
REQ-030 SHALL ignore stall and flush while rst=0.

Verification
REQ-031 SHALL cover one-word instruction: in_instruction=16'h2345, in_pc=5, in_next_pc=6 -> next edge out_instruction=16'h2345, out_pc=5, out_next_pc=6, out_valid=1, out_has_imm=0.
REQ-032 SHALL cover two-word instruction: 16'hC123 at pc 8, then 16'hBEEF at pc 9 (next 10) -> bubble with out_valid=0 and imm_pending=1, then out_instruction=16'hC123, out_immediate=16'hBEEF, out_pc=8, out_next_pc=10, out_valid=1, out_has_imm=1.
REQ-033 SHALL cover immediate word shaped like an opcode: 16'hC001 followed by 16'hC002 -> single instruction 16'hC001 with immediate 16'hC002; next word is decoded as an opcode.
REQ-034 SHALL cover stall in S_IMM: 16'hC123 at pc 8, stall=1 for 3 cycles with in_instruction changing -> outputs and imm_pending frozen; after stall drops, immediate is taken from the first unstalled word.
REQ-035 SHALL cover flush+stall together in S_IMM -> next edge out_valid=0, out_instruction=16'h0000, imm_pending=0, pending discarded.
REQ-036 SHALL cover asynchronous reset mid-cycle in S_IMM -> outputs at reset values before the next clk edge; first post-reset word 16'h2345 is handled per REQ-019.
